acumulador_moedas: RTL and testbench
====================================

ACUMULADOR_MOEDAS -- requirements
Module: acumulador_moedas

Parameters
REQ-001 The block SHALL have parameter TIMEOUT_CICLOS, default 1000, meaning idle cycles in COLETANDO before an automatic cancel.
REQ-002 The block SHALL have parameter HOLD_CICLOS, default 4, meaning the number of cycles enable is held high toward the comparator.

Interface
REQ-003 The block SHALL have port clk  input  1  system clock, rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port moeda1  input  1  single-cycle pulse; one coin worth 1 unit inserted.
REQ-006 The block SHALL have port moeda2  input  1  single-cycle pulse; one coin worth 2 units inserted.
REQ-007 The block SHALL have port selecao  input  3  product code from the keypad, sampled on confirmar.
REQ-008 The block SHALL have port confirmar  input  1  single-cycle pulse; user confirms the purchase.
REQ-009 The block SHALL have port cancelar  input  1  single-cycle pulse; user aborts the purchase.
REQ-010 The block SHALL have port valorMoedas  output  4  registered coin total presented to the comparator.
REQ-011 The block SHALL have port valorProduto  output  3  registered product code presented to the comparator.
REQ-012 The block SHALL have port enable  output  1  comparator strobe, high for exactly HOLD_CICLOS cycles per transaction.
REQ-013 The block SHALL have port rejeitarMoeda  output  1  one-cycle pulse; the coin inserted this cycle was not accepted.
REQ-014 The block SHALL have port ocupado  output  1  high in COMPARAR and ESPERA; coins are refused.

Function
REQ-015 The block SHALL implement states OCIOSO, COLETANDO, COMPARAR and ESPERA.
REQ-016 In OCIOSO or COLETANDO, an accepted coin SHALL add 1 (moeda1), 2 (moeda2) or 3 (both in the same cycle) to valorMoedas on the next clock edge.
REQ-017 A coin SHALL be rejected if the new total would exceed 15; in that case valorMoedas SHALL stay unchanged and rejeitarMoeda SHALL pulse on the next cycle.
REQ-018 If the moeda1+moeda2 sum overflows, both coins of that cycle SHALL be rejected.
REQ-019 An accepted coin in OCIOSO SHALL move the state to COLETANDO.
REQ-020 confirmar and cancelar SHALL be ignored in OCIOSO.
REQ-021 In COLETANDO, confirmar SHALL latch selecao into valorProduto and move the state to COMPARAR.
REQ-022 In COLETANDO, cancelar SHALL force valorProduto to 000 and move the state to COMPARAR, so the comparator returns the coins.
REQ-023 If confirmar and cancelar are both high in the same cycle, cancelar SHALL win.
REQ-024 If a coin arrives in the same cycle as confirmar or cancelar, the coin SHALL be accepted first, and the new total SHALL be the value presented.
REQ-025 The idle timer SHALL reset to 0 on entry to COLETANDO and on every accepted coin, and SHALL increment on every other COLETANDO cycle.
REQ-026 When the idle timer reaches TIMEOUT_CICLOS-1, the block SHALL behave as if cancelar were asserted.
REQ-027 In COMPARAR, enable SHALL be 1 for HOLD_CICLOS cycles, with valorMoedas and valorProduto stable; the state SHALL then move to ESPERA.
REQ-028 In ESPERA, enable SHALL be 0 for one cycle; valorMoedas and valorProduto SHALL then clear to 0 and the state SHALL move to OCIOSO.
REQ-029 Any coin in COMPARAR or ESPERA SHALL pulse rejeitarMoeda; confirmar and cancelar SHALL be ignored in those states.
REQ-030 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-031 While reset_n=0, asynchronously: state=OCIOSO, valorMoedas=0, valorProduto=0, enable=0, rejeitarMoeda=0, ocupado=0, idle timer=0.
REQ-032 Reset asserted mid-transaction, including during COMPARAR, SHALL discard the total and drop enable immediately.
REQ-033 The first transition after reset_n deasserts SHALL occur on the next rising clk edge.

Verification
REQ-034 Directed test: moeda2, moeda2, then confirmar with selecao=010 -> valorMoedas=4, valorProduto=010, enable high 4 cycles, then outputs=0 and the state is OCIOSO.
REQ-035 Directed test: moeda1 and moeda2 in the same cycle, then confirmar with selecao=001 -> valorMoedas=3, enable pulses with valorProduto=001.
REQ-036 Directed test: seven moeda2 (total 14), then moeda2 -> total stays 14, rejeitarMoeda=1 for one cycle; then moeda1 -> total 15.
REQ-037 Directed test: one moeda1, then no activity for TIMEOUT_CICLOS cycles -> COMPARAR with valorMoedas=1, valorProduto=000.
REQ-038 Directed test: confirmar and cancelar in the same cycle, then moeda1 during COMPARAR -> valorProduto=000, rejeitarMoeda pulses, total unchanged.
REQ-039 Directed test: reset_n low during cycle 2 of enable -> enable=0 and valorMoedas=0 with no clock edge.

Source files
------------

// File: rtl/acumulador_moedas.sv
// acumulador_moedas
//   Coin accumulator front-end for a vending machine. Sums coin pulses into a
//   4-bit total (saturating by rejection above 15), captures the product code
//   on confirmation (or 000 on cancel/timeout) and strobes a downstream
//   comparator for HOLD_CICLOS cycles, then clears and returns to idle.
//
// Ports
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   moeda1         in   pulse: 1-unit coin inserted
//   moeda2         in   pulse: 2-unit coin inserted
//   selecao[2:0]   in   product code, sampled on confirmar
//   confirmar      in   pulse: confirm purchase
//   cancelar       in   pulse: abort purchase
//   valorMoedas    out  registered coin total
//   valorProduto   out  registered product code
//   enable         out  comparator strobe, HOLD_CICLOS cycles per transaction
//   rejeitarMoeda  out  one-cycle pulse: coin of previous cycle refused
//   ocupado        out  high while comparing/waiting; coins refused
module acumulador_moedas #(
    parameter int unsigned TIMEOUT_CICLOS = 1000,
    parameter int unsigned HOLD_CICLOS    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       moeda1,
    input  logic       moeda2,
    input  logic [2:0] selecao,
    input  logic       confirmar,
    input  logic       cancelar,
    output logic [3:0] valorMoedas,
    output logic [2:0] valorProduto,
    output logic       enable,
    output logic       rejeitarMoeda,
    output logic       ocupado
);

    localparam int unsigned TW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam int unsigned HW = (HOLD_CICLOS > 2) ? $clog2(HOLD_CICLOS) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        COLETANDO,
        COMPARAR,
        ESPERA
    } estado_t;

    estado_t       state_q, state_d;
    logic [3:0]    valor_moedas_q, valor_moedas_d;
    logic [2:0]    valor_produto_q, valor_produto_d;
    logic          enable_q, enable_d;
    logic          rejeitar_q, rejeitar_d;
    logic          ocupado_q, ocupado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [4:0]    soma;
    logic [4:0]    total_novo;
    logic          tem_moeda;
    logic          aceita;
    logic          desiste;

    // Both coins of a cycle are judged together: if their combined value
    // would overflow the 4-bit total, neither is accepted.
    always_comb begin
        soma       = {4'b0, moeda1} + {3'b0, moeda2, 1'b0};
        total_novo = {1'b0, valor_moedas_q} + soma;
        tem_moeda  = moeda1 | moeda2;
        aceita     = tem_moeda && (total_novo <= 5'd15);
        desiste    = cancelar || (timer_q == TIMER_MAX);
    end

    always_comb begin
        state_d         = state_q;
        valor_moedas_d  = valor_moedas_q;
        valor_produto_d = valor_produto_q;
        timer_d         = timer_q;
        hold_d          = hold_q;
        enable_d        = 1'b0;
        rejeitar_d      = 1'b0;
        ocupado_d       = 1'b0;

        case (state_q)
            OCIOSO: begin
                if (aceita) begin
                    valor_moedas_d = total_novo[3:0];
                    timer_d        = '0;
                    state_d        = COLETANDO;
                end else begin
                    rejeitar_d = tem_moeda;
                end
            end

            COLETANDO: begin
                // A coin arriving with confirmar/cancelar is accounted first,
                // so the total presented already includes it.
                if (aceita) begin
                    valor_moedas_d = total_novo[3:0];
                end else begin
                    rejeitar_d = tem_moeda;
                end

                if (desiste || confirmar) begin
                    valor_produto_d = desiste ? 3'b000 : selecao;
                    hold_d          = '0;
                    enable_d        = 1'b1;
                    ocupado_d       = 1'b1;
                    state_d         = COMPARAR;
                end else if (aceita) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            COMPARAR: begin
                rejeitar_d = tem_moeda;
                ocupado_d  = 1'b1;
                if (hold_q == HOLD_MAX) begin
                    state_d = ESPERA;
                end else begin
                    hold_d   = hold_q + HW'(1);
                    enable_d = 1'b1;
                end
            end

            ESPERA: begin
                rejeitar_d      = tem_moeda;
                valor_moedas_d  = '0;
                valor_produto_d = '0;
                state_d         = OCIOSO;
            end

            default: begin
                state_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= OCIOSO;
            valor_moedas_q  <= '0;
            valor_produto_q <= '0;
            enable_q        <= 1'b0;
            rejeitar_q      <= 1'b0;
            ocupado_q       <= 1'b0;
            timer_q         <= '0;
            hold_q          <= '0;
        end else begin
            state_q         <= state_d;
            valor_moedas_q  <= valor_moedas_d;
            valor_produto_q <= valor_produto_d;
            enable_q        <= enable_d;
            rejeitar_q      <= rejeitar_d;
            ocupado_q       <= ocupado_d;
            timer_q         <= timer_d;
            hold_q          <= hold_d;
        end
    end

    assign valorMoedas   = valor_moedas_q;
    assign valorProduto  = valor_produto_q;
    assign enable        = enable_q;
    assign rejeitarMoeda = rejeitar_q;
    assign ocupado       = ocupado_q;

endmodule

// File: tb/tb_acumulador_moedas.sv
// Self-checking bench for acumulador_moedas: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model of the accumulator.
module tb_acumulador_moedas;

    localparam int unsigned T = 24;
    localparam int unsigned H = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       moeda1 = 1'b0;
    logic       moeda2 = 1'b0;
    logic [2:0] selecao = 3'b000;
    logic       confirmar = 1'b0;
    logic       cancelar = 1'b0;
    logic [3:0] valorMoedas;
    logic [2:0] valorProduto;
    logic       enable;
    logic       rejeitarMoeda;
    logic       ocupado;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    acumulador_moedas #(.TIMEOUT_CICLOS(T), .HOLD_CICLOS(H)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .moeda1       (moeda1),
        .moeda2       (moeda2),
        .selecao      (selecao),
        .confirmar    (confirmar),
        .cancelar     (cancelar),
        .valorMoedas  (valorMoedas),
        .valorProduto (valorProduto),
        .enable       (enable),
        .rejeitarMoeda(rejeitarMoeda),
        .ocupado      (ocupado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: total/product plus a countdown of busy cycles
    // (H strobe cycles followed by one wait cycle).
    int m_total, m_prod, m_busy, m_idle;
    bit m_coll, m_rej;

    always @(posedge clk or negedge reset_n) begin
        int  coins;
        bit  ok, quit;
        if (!reset_n) begin
            m_total = 0; m_prod = 0; m_busy = 0; m_idle = 0;
            m_coll = 0;  m_rej = 0;
        end else begin
            coins = int'(moeda1) + 2 * int'(moeda2);
            m_rej = 0;
            if (m_busy > 0) begin
                m_rej = (coins != 0);
                m_busy--;
                if (m_busy == 0) begin
                    m_total = 0;
                    m_prod  = 0;
                end
            end else begin
                ok = (coins != 0) && (m_total + coins <= 15);
                if (coins != 0 && !ok) m_rej = 1;
                if (ok) m_total += coins;
                if (m_coll) begin
                    quit = cancelar || (m_idle == T - 1);
                    if (quit || confirmar) begin
                        m_prod = quit ? 0 : int'(selecao);
                        m_busy = H + 1;
                        m_coll = 0;
                    end else begin
                        m_idle = ok ? 0 : m_idle + 1;
                    end
                end else if (ok) begin
                    m_coll = 1;
                    m_idle = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("valorMoedas",   int'(valorMoedas),   m_total);
            chk("valorProduto",  int'(valorProduto),  m_prod);
            chk("enable",        int'(enable),        int'(m_busy > 1));
            chk("ocupado",       int'(ocupado),       int'(m_busy > 0));
            chk("rejeitarMoeda", int'(rejeitarMoeda), int'(m_rej));
        end
    end

    task automatic drive(input logic m1, input logic m2, input logic [2:0] sel,
                         input logic cf, input logic cn);
        @(negedge clk);
        moeda1 = m1; moeda2 = m2; selecao = sel; confirmar = cf; cancelar = cn;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 3'b000, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        #12;
        chk("reset_valorMoedas", int'(valorMoedas), 0);
        chk("reset_enable",      int'(enable), 0);
        chk("reset_ocupado",     int'(ocupado), 0);
        @(negedge clk);
        reset_n = 1'b1;
        cmp_on  = 1'b1;

        // two 2-unit coins, confirm product 010
        drive(0, 1, 3'b000, 0, 0);
        drive(0, 1, 3'b000, 0, 0);
        drive(0, 0, 3'b010, 1, 0);
        idle(1);
        chk("d1_total", int'(valorMoedas), 4);
        chk("d1_prod",  int'(valorProduto), 2);
        chk("d1_en",    int'(enable), 1);
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            cnt += int'(enable);
        end
        chk("d1_en_cycles", cnt, 4);
        chk("d1_clear_total", int'(valorMoedas), 0);
        chk("d1_clear_busy",  int'(ocupado), 0);

        // both coins in one cycle, confirm 001
        drive(1, 1, 3'b000, 0, 0);
        drive(0, 0, 3'b001, 1, 0);
        idle(1);
        chk("d2_total", int'(valorMoedas), 3);
        chk("d2_prod",  int'(valorProduto), 1);
        chk("d2_en",    int'(enable), 1);
        idle(8);

        // fill to 14, overflow rejected, then top up to 15
        for (int i = 0; i < 7; i++) drive(0, 1, 3'b000, 0, 0);
        drive(0, 1, 3'b000, 0, 0);
        idle(1);
        chk("d3_total14", int'(valorMoedas), 14);
        chk("d3_rej",     int'(rejeitarMoeda), 1);
        idle(1);
        chk("d3_rej_pulse", int'(rejeitarMoeda), 0);
        drive(1, 0, 3'b000, 0, 0);
        idle(1);
        chk("d3_total15", int'(valorMoedas), 15);
        drive(0, 0, 3'b000, 0, 1);
        idle(8);

        // idle timeout
        drive(1, 0, 3'b000, 0, 0);
        idle(T);
        chk("d4_not_yet", int'(ocupado), 0);
        idle(1);
        chk("d4_busy",  int'(ocupado), 1);
        chk("d4_total", int'(valorMoedas), 1);
        chk("d4_prod",  int'(valorProduto), 0);
        idle(8);

        // confirm+cancel together, coin while comparing
        drive(1, 0, 3'b000, 0, 0);
        drive(0, 0, 3'b101, 1, 1);
        drive(1, 0, 3'b000, 0, 0);
        idle(1);
        chk("d5_prod",  int'(valorProduto), 0);
        chk("d5_rej",   int'(rejeitarMoeda), 1);
        chk("d5_total", int'(valorMoedas), 1);
        idle(8);

        // asynchronous reset in the second strobe cycle
        drive(0, 1, 3'b000, 0, 0);
        drive(0, 0, 3'b011, 1, 0);
        idle(2);
        chk("d6_en_before", int'(enable), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("d6_en",    int'(enable), 0);
        chk("d6_total", int'(valorMoedas), 0);
        chk("d6_busy",  int'(ocupado), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // randomized traffic, alternating busy and sparse phases
        for (int i = 0; i < 4000; i++) begin
            int p;
            p = ((i / 500) % 2 == 0) ? 30 : 4;
            drive($urandom_range(99) < p, $urandom_range(99) < p,
                  3'($urandom_range(7)),
                  $urandom_range(99) < 6, $urandom_range(99) < 3);
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
